// File: rtl/sa_result_reader.sv
// Purpose : snapshots the NxN result tile of the systolic array a fixed latency after
//           MATMUL starts, then streams it out one row per valid/ready beat.
// Latency : snapshot at edge DRAIN_LAT after START; row 0 valid right after that edge.
// Backpr. : OUT_VALID holds until accepted; row data/index/last stay stable while
//           OUT_READY=0. A START arriving while busy is dropped and flagged on OVERRUN.
//
// Ports:
//   CLK, RST_N   clock (rising edge) and asynchronous active-low reset
//   START        one-cycle pulse at MATMUL start
//   Y_IN         flattened array outputs, element (r,c) at [(r*N+c)*DW +: DW]
//   OUT_DATA     current row, column c at [c*DW +: DW]; zero when not valid
//   OUT_ROW      row index on OUT_DATA; zero when not valid
//   OUT_VALID    row beat valid
//   OUT_READY    downstream accepts the beat
//   OUT_LAST     high with the final row beat
//   BUSY         waiting for results or streaming them
//   OVERRUN      one-cycle pulse the cycle after a dropped START
module sa_result_reader #(
    parameter int DW        = 16,
    parameter int N         = 8,
    parameter int DRAIN_LAT = 22
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    input  logic [N*N*DW-1:0]     Y_IN,
    output logic [N*DW-1:0]       OUT_DATA,
    output logic [$clog2(N)-1:0]  OUT_ROW,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic                  OUT_LAST,
    output logic                  BUSY,
    output logic                  OVERRUN
);

    localparam int RW = $clog2(N);

    // Counter is loaded with DRAIN_LAT-1 on the START edge and the snapshot happens
    // on the edge after it reads zero, which places the snapshot at edge DRAIN_LAT.
    localparam logic [7:0]    LAT_INIT = 8'(DRAIN_LAT - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [RW-1:0]       row_q, row_d;
    logic                ovr_q, ovr_d;
    logic                snap;
    logic [N*N*DW-1:0]   buf_q;

    // ------------------------------------------------------------------
    // State, counter, row pointer and overrun flag
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            row_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            ovr_q   <= ovr_d;
        end
    end

    // Result buffer. Its contents are only meaningful once a snapshot has been
    // taken; before that every output that could expose it is masked by
    // OUT_VALID, so it carries no reset.
    always_ff @(posedge CLK) begin
        if (snap) begin
            buf_q <= Y_IN;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        snap    = 1'b0;
        // Any START seen outside IDLE is dropped, including one that lands on
        // the final handshake edge: that edge still sees state STREAM.
        ovr_d   = START && (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    cnt_d   = LAT_INIT;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (cnt_q == 8'd0) begin
                    snap    = 1'b1;
                    row_d   = '0;
                    state_d = S_STREAM;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            S_STREAM: begin
                // OUT_VALID is unconditionally high here, so READY alone
                // completes the handshake.
                if (OUT_READY) begin
                    if (row_q == LAST_ROW) begin
                        row_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: everything row-related is zeroed whenever no beat is offered
    // ------------------------------------------------------------------
    always_comb begin
        OUT_VALID = (state_q == S_STREAM);
        OUT_DATA  = '0;
        OUT_ROW   = '0;
        OUT_LAST  = 1'b0;
        if (OUT_VALID) begin
            for (int c = 0; c < N; c++) begin
                OUT_DATA[c*DW +: DW] = buf_q[(int'(row_q)*N + c)*DW +: DW];
            end
            OUT_ROW  = row_q;
            OUT_LAST = (row_q == LAST_ROW);
        end
        BUSY    = (state_q != S_IDLE);
        OVERRUN = ovr_q;
    end

endmodule

// File: tb/tb_sa_result_reader.sv
module tb_sa_result_reader;

    localparam int DW = 16;
    localparam int N  = 8;
    localparam int DL = 22;

    logic              clk;
    logic              rst_n;
    logic              start, start1;
    logic [N*N*DW-1:0] y_in;
    logic [N*DW-1:0]   out_data, out_data1;
    logic [2:0]        out_row, out_row1;
    logic              out_valid, out_valid1;
    logic              out_ready, out_ready1;
    logic              out_last, out_last1;
    logic              busy, busy1;
    logic              overrun, overrun1;

    int checks;
    int failures;

    // Reference model: the tile the bench drove on Y_IN at the snapshot edge.
    logic [DW-1:0] ymat [N][N];
    logic [DW-1:0] expm [N][N];

    sa_result_reader #(.DW(DW), .N(N), .DRAIN_LAT(DL)) dut (
        .CLK(clk), .RST_N(rst_n), .START(start), .Y_IN(y_in),
        .OUT_DATA(out_data), .OUT_ROW(out_row), .OUT_VALID(out_valid),
        .OUT_READY(out_ready), .OUT_LAST(out_last), .BUSY(busy), .OVERRUN(overrun)
    );

    sa_result_reader #(.DW(DW), .N(N), .DRAIN_LAT(1)) dut1 (
        .CLK(clk), .RST_N(rst_n), .START(start1), .Y_IN(y_in),
        .OUT_DATA(out_data1), .OUT_ROW(out_row1), .OUT_VALID(out_valid1),
        .OUT_READY(out_ready1), .OUT_LAST(out_last1), .BUSY(busy1), .OVERRUN(overrun1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic pack_y();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                y_in[(r*N+c)*DW +: DW] = ymat[r][c];
    endtask

    task automatic fill_y(input bit pattern);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                if (pattern) ymat[r][c] = DW'((r << 12) | (c << 8)) + 16'd1;
                else         ymat[r][c] = DW'($urandom);
                expm[r][c] = ymat[r][c];
            end
        pack_y();
    endtask

    task automatic flood_y();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                ymat[r][c] = 16'hFFFF;
        pack_y();
    endtask

    function automatic logic [N*DW-1:0] exp_row(input int r);
        logic [N*DW-1:0] v;
        v = '0;
        for (int c = 0; c < N; c++) v[c*DW +: DW] = expm[r][c];
        return v;
    endfunction

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; start1 = 1'b0;
        out_ready = 1'b0; out_ready1 = 1'b0;
        fill_y(1'b0);
        #3;
        checks++;
        if ({busy, out_valid, out_last, overrun, out_row} !== 7'd0 || out_data !== '0) begin
            failures++;
            $display("FAIL reset_outputs busy=%b valid=%b last=%b ovr=%b row=%0d data=%h required all 0",
                     busy, out_valid, out_last, overrun, out_row, out_data);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, out_valid, out_last, overrun, out_row} !== 7'd0 || out_data !== '0 ||
                {busy1, out_valid1, overrun1} !== 3'd0) begin
                failures++;
                $display("FAIL idle_outputs cycle=%0d busy=%b valid=%b last=%b ovr=%b row=%0d busy1=%b valid1=%b required all 0",
                         i, busy, out_valid, out_last, overrun, out_row, busy1, out_valid1);
            end
        end
    endtask

    // One complete transfer on the DRAIN_LAT=22 instance.
    //   bp      : random OUT_READY instead of constant 1
    //   isolate : flood Y_IN with FFFF right after the snapshot edge
    //   ovr     : extra START at E10 and on the row N-1 handshake
    task automatic run_transfer(input bit bp, input bit isolate, input bit ovr,
                                input bit pattern, input string name);
        int              beats;
        int              cyc;
        int              ovr_seen;
        bit              hold;
        logic [N*DW-1:0] prev_data;
        logic [2:0]      prev_row;

        fill_y(pattern);
        ovr_seen = 0;
        @(negedge clk);
        start = 1'b1;
        out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk);                               // E0
        for (int k = 0; k < DL; k++) begin
            @(negedge clk);                           // after E_k
            start = 1'b0;
            checks++;
            if (overrun !== (ovr && k == 10)) begin
                failures++;
                $display("FAIL %s wait_overrun k=%0d got=%b required=%b", name, k, overrun, (ovr && k == 10));
            end
            if (overrun === 1'b1) ovr_seen++;
            checks++;
            if (busy !== 1'b1 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL %s wait_state k=%0d busy=%b valid=%b required busy=1 valid=0", name, k, busy, out_valid);
            end
            if (bp) out_ready = 1'($urandom_range(0, 1));
            if (ovr && k == 9) start = 1'b1;
            @(posedge clk);                           // E_{k+1}
        end

        beats = 0; cyc = 0; hold = 1'b0;
        prev_data = '0; prev_row = '0;
        while (beats < N && cyc < 200) begin
            @(negedge clk);
            start = 1'b0;
            if (isolate && cyc == 0) flood_y();
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || overrun !== 1'b0) begin
                failures++;
                $display("FAIL %s stream_ctrl beat=%0d valid=%b busy=%b ovr=%b required 1,1,0",
                         name, beats, out_valid, busy, overrun);
            end
            checks++;
            if (out_row !== 3'(beats) || out_last !== (beats == N-1)) begin
                failures++;
                $display("FAIL %s stream_row got row=%0d last=%b required row=%0d last=%b",
                         name, out_row, out_last, beats, (beats == N-1));
            end
            checks++;
            if (out_data !== exp_row(beats)) begin
                failures++;
                $display("FAIL %s stream_data row=%0d got=%h required=%h", name, beats, out_data, exp_row(beats));
            end
            if (hold) begin
                checks++;
                if (out_data !== prev_data || out_row !== prev_row) begin
                    failures++;
                    $display("FAIL %s hold_stable got row=%0d data=%h required row=%0d data=%h",
                             name, out_row, out_data, prev_row, prev_data);
                end
            end
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ovr && beats == N-1 && out_ready) start = 1'b1;
            hold = !out_ready;
            prev_data = out_data;
            prev_row = out_row;
            @(posedge clk);
            if (out_ready) beats++;
            cyc++;
        end
        checks++;
        if (beats != N || (!bp && cyc != N)) begin
            failures++;
            $display("FAIL %s beat_count got=%0d in %0d cycles required=%0d", name, beats, cyc, N);
        end

        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({busy, out_valid, out_last, out_row} !== 6'd0 || out_data !== '0) begin
            failures++;
            $display("FAIL %s post_idle busy=%b valid=%b last=%b row=%0d data=%h required all 0",
                     name, busy, out_valid, out_last, out_row, out_data);
        end
        checks++;
        if (overrun !== ovr) begin
            failures++;
            $display("FAIL %s final_overrun got=%b required=%b", name, overrun, ovr);
        end
        if (overrun === 1'b1) ovr_seen++;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || overrun !== 1'b0 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL %s dropped_start busy=%b ovr=%b valid=%b required 0,0,0", name, busy, overrun, out_valid);
            end
        end
        if (ovr) begin
            checks++;
            if (ovr_seen != 2) begin
                failures++;
                $display("FAIL %s overrun_pulses got=%0d required=2", name, ovr_seen);
            end
        end
    endtask

    task automatic test_basic_drain();
        run_transfer(1'b0, 1'b0, 1'b0, 1'b1, "basic");
    endtask

    task automatic test_snapshot_isolation();
        run_transfer(1'b0, 1'b1, 1'b0, 1'b0, "isolate");
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 3; i++) run_transfer(1'b1, 1'b0, 1'b0, 1'b0, "backpressure");
    endtask

    task automatic test_overrun();
        run_transfer(1'b0, 1'b0, 1'b1, 1'b0, "overrun");
        run_transfer(1'b1, 1'b1, 1'b1, 1'b0, "overrun_bp");
    endtask

    task automatic test_reset_midstream();
        int cyc;
        fill_y(1'b0);
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (DL - 1) @(posedge clk);
        // Three handshakes with READY high, then stall on row 3.
        cyc = 0;
        @(negedge clk);
        while (out_row !== 3'd3 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        checks++;
        if (out_row !== 3'd3 || out_valid !== 1'b1 || out_data !== exp_row(3)) begin
            failures++;
            $display("FAIL midreset_row3 got row=%0d valid=%b required row=3 valid=1", out_row, out_valid);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0 || out_row !== 3'd0) begin
            failures++;
            $display("FAIL midreset_async valid=%b busy=%b row=%0d required valid=0 busy=0 row=0",
                     out_valid, busy, out_row);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL midreset_abort valid=%b busy=%b required 0,0", out_valid, busy);
            end
        end
        run_transfer(1'b0, 1'b0, 1'b0, 1'b0, "after_reset");
    endtask

    // DRAIN_LAT=1 instance: snapshot on E1, single WAIT cycle.
    task automatic test_min_latency();
        int beats;
        fill_y(1'b0);
        @(negedge clk);
        start1 = 1'b1;
        out_ready1 = 1'b1;
        @(posedge clk);                               // E0
        @(negedge clk);
        start1 = 1'b0;
        checks++;
        if (busy1 !== 1'b1 || out_valid1 !== 1'b0) begin
            failures++;
            $display("FAIL lat1_wait busy=%b valid=%b required busy=1 valid=0", busy1, out_valid1);
        end
        @(posedge clk);                               // E1: snapshot
        beats = 0;
        while (beats < N) begin
            @(negedge clk);
            if (beats == 0) flood_y();
            checks++;
            if (out_valid1 !== 1'b1 || out_row1 !== 3'(beats) || out_data1 !== exp_row(beats) ||
                out_last1 !== (beats == N-1)) begin
                failures++;
                $display("FAIL lat1_beat got valid=%b row=%0d last=%b data=%h required valid=1 row=%0d data=%h",
                         out_valid1, out_row1, out_last1, out_data1, beats, exp_row(beats));
            end
            @(posedge clk);
            beats++;
        end
        @(negedge clk);
        checks++;
        if (busy1 !== 1'b0 || out_valid1 !== 1'b0 || overrun1 !== 1'b0) begin
            failures++;
            $display("FAIL lat1_done busy=%b valid=%b ovr=%b required 0,0,0", busy1, out_valid1, overrun1);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic_drain();
        test_snapshot_isolation();
        test_backpressure();
        test_overrun();
        test_reset_midstream();
        test_min_latency();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
